// File: rtl/key_nibble_entry_if.sv
// Signal bundle between the board keys, the nibble entry stage and the
// display decoder that consumes its value and clean key levels.
interface key_nibble_entry_if;
    logic [3:0] KEY;      // raw board keys, active-low, asynchronous
    logic [3:0] value;    // current entered nibble
    logic [3:0] pressed;  // debounced key levels, active-high
    logic       locked;   // entry lock state
    logic       update;   // one-cycle pulse when value changes

    // Entry stage: samples the keys, produces value and status
    modport master (
        input  KEY,
        output value,
        output pressed,
        output locked,
        output update
    );

    // Key source / display decoder side
    modport slave (
        output KEY,
        input  value,
        input  pressed,
        input  locked,
        input  update
    );
endinterface

// File: rtl/key_nibble_entry.sv
// Debounced push-button nibble entry. Synchronizes and debounces four
// active-low keys, turns debounced presses into single events, and steps a
// 4-bit value (inc / dec / clear) with a lock toggle on KEY[3].
module key_nibble_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    key_nibble_entry_if.master bus
);

    // The counter only needs to reach DEBOUNCE_CYCLES-1: the threshold cycle
    // itself is the one that flips the debounced level and clears the count.
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       pressed_q, pressed_d;
    logic [3:0]       pressed_prev_q, pressed_prev_d;
    logic [3:0]       value_q, value_d;
    logic             locked_q, locked_d;
    logic             update_q, update_d;
    logic [3:0]       ev;

    // Two-flop synchronizer on the inverted keys (1 = pressed)
    always_comb begin
        sync1_d = ~bus.KEY;
        sync2_d = sync1_q;
    end

    // Per-key debounce: count consecutive disagreeing cycles, any agreement restarts
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i]     = '0;
            pressed_d[i] = pressed_q[i];
            if (sync2_q[i] != pressed_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    pressed_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Press events on debounced rising edges; releases are ignored
    always_comb begin
        pressed_prev_d = pressed_q;
        ev             = pressed_q & ~pressed_prev_q;
    end

    // Key functions; all edits see the lock state from before any same-cycle toggle
    always_comb begin
        locked_d = locked_q ^ ev[3];
        value_d  = value_q;
        if (!locked_q) begin
            if (ev[2]) begin
                value_d = 4'd0;
            end else if (ev[0] ^ ev[1]) begin
                value_d = ev[0] ? (value_q + 4'd1) : (value_q - 4'd1);
            end
        end
        update_d = (value_d != value_q);
    end

    // State registers; everything clears on asynchronous reset
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            pressed_q      <= '0;
            pressed_prev_q <= '0;
            value_q        <= '0;
            locked_q       <= 1'b0;
            update_q       <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pressed_q      <= pressed_d;
            pressed_prev_q <= pressed_prev_d;
            value_q        <= value_d;
            locked_q       <= locked_d;
            update_q       <= update_d;
        end
    end

    assign bus.value   = value_q;
    assign bus.pressed = pressed_q;
    assign bus.locked  = locked_q;
    assign bus.update  = update_q;

endmodule

// File: tb/tb_key_nibble_entry.sv
// Directed self-checking bench for key_nibble_entry with DEBOUNCE_CYCLES=4.
module tb_key_nibble_entry;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   upd_cnt;
    int   rise1_cnt;
    logic p1_prev;
    int   snap_u;
    int   snap_r;

    key_nibble_entry_if bus();

    key_nibble_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count update pulses and pressed[1] rising edges, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            p1_prev <= 1'b0;
        end else begin
            p1_prev <= bus.pressed[1];
            if (bus.update === 1'b1) upd_cnt <= upd_cnt + 1;
            if (bus.pressed[1] === 1'b1 && p1_prev === 1'b0) rise1_cnt <= rise1_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Press the keys in mask together, hold long enough for one event, release
    task automatic press(input logic [3:0] mask);
        bus.KEY = 4'hF & ~mask;
        tick(10);
        bus.KEY = 4'hF;
        tick(10);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        upd_cnt   = 0;
        rise1_cnt = 0;
        bus.KEY   = 4'hF;
        rst       = 1'b0;
        #2 rst    = 1'b1;
        #1;
        chk("reset_value",   {4'd0, bus.value},   8'h00);
        chk("reset_pressed", {4'd0, bus.pressed}, 8'h00);
        chk("reset_locked",  {7'd0, bus.locked},  8'h00);
        chk("reset_update",  {7'd0, bus.update},  8'h00);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Clean press on KEY[0]
        bus.KEY = 4'b1110;
        tick(5);
        chk("clean_pressed_before", {4'd0, bus.pressed}, 8'h00);
        tick(1);
        chk("clean_pressed_rise", {4'd0, bus.pressed}, 8'h01);
        chk("clean_value_before", {4'd0, bus.value}, 8'h00);
        tick(1);
        chk("clean_value", {4'd0, bus.value}, 8'h01);
        chk("clean_update", {7'd0, bus.update}, 8'h01);
        tick(1);
        chk("clean_update_width", {7'd0, bus.update}, 8'h00);
        tick(12);
        chk("clean_hold_value", {4'd0, bus.value}, 8'h01);
        bus.KEY = 4'hF;
        tick(5);
        chk("clean_release_before", {4'd0, bus.pressed}, 8'h01);
        tick(1);
        chk("clean_release", {4'd0, bus.pressed}, 8'h00);
        tick(4);
        chk("clean_release_value", {4'd0, bus.value}, 8'h01);

        // Bounce on KEY[1] starting from 3
        press(4'b0001);
        press(4'b0001);
        chk("bounce_start", {4'd0, bus.value}, 8'h03);
        snap_u = upd_cnt;
        snap_r = rise1_cnt;
        for (int i = 0; i < 6; i++) begin
            bus.KEY = (i % 2 == 0) ? 4'b1101 : 4'b1111;
            tick(2);
        end
        bus.KEY = 4'b1101;
        tick(12);
        chk("bounce_pressed", {4'd0, bus.pressed}, 8'h02);
        chk("bounce_value", {4'd0, bus.value}, 8'h02);
        chk("bounce_updates", 8'(upd_cnt - snap_u), 8'd1);
        chk("bounce_rises", 8'(rise1_cnt - snap_r), 8'd1);
        bus.KEY = 4'hF;
        tick(10);

        // Wrap: 2 -> 1 -> 0 -> 15
        press(4'b0010);
        press(4'b0010);
        press(4'b0010);
        chk("wrap_down_to_15", {4'd0, bus.value}, 8'h0F);
        snap_u = upd_cnt;
        press(4'b0001);
        chk("wrap_up_value", {4'd0, bus.value}, 8'h00);
        chk("wrap_up_update", 8'(upd_cnt - snap_u), 8'd1);
        press(4'b0010);
        chk("wrap_down_value", {4'd0, bus.value}, 8'h0F);
        press(4'b0100);
        chk("clear_from_15", {4'd0, bus.value}, 8'h00);
        snap_u = upd_cnt;
        press(4'b0100);
        chk("clear_at_0_value", {4'd0, bus.value}, 8'h00);
        chk("clear_at_0_update", 8'(upd_cnt - snap_u), 8'd0);

        // Lock
        for (int i = 0; i < 5; i++) press(4'b0001);
        chk("lock_start", {4'd0, bus.value}, 8'h05);
        press(4'b1000);
        chk("lock_on", {7'd0, bus.locked}, 8'h01);
        snap_u = upd_cnt;
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        chk("locked_value", {4'd0, bus.value}, 8'h05);
        chk("locked_update", 8'(upd_cnt - snap_u), 8'd0);
        press(4'b1000);
        chk("lock_off", {7'd0, bus.locked}, 8'h00);
        press(4'b0001);
        chk("unlocked_inc", {4'd0, bus.value}, 8'h06);

        // Simultaneous events
        press(4'b0001);
        press(4'b0001);
        press(4'b0001);
        chk("simul_start", {4'd0, bus.value}, 8'h09);
        snap_u = upd_cnt;
        press(4'b0011);
        chk("inc_dec_value", {4'd0, bus.value}, 8'h09);
        chk("inc_dec_update", 8'(upd_cnt - snap_u), 8'd0);
        press(4'b0101);
        chk("clear_beats_inc", {4'd0, bus.value}, 8'h00);
        press(4'b1001);
        chk("lock_inc_value", {4'd0, bus.value}, 8'h01);
        chk("lock_inc_locked", {7'd0, bus.locked}, 8'h01);
        press(4'b1000);
        chk("unlock_again", {7'd0, bus.locked}, 8'h00);

        // Reset while KEY[0] is held
        press(4'b0001);
        press(4'b0001);
        press(4'b0001);
        bus.KEY = 4'b1110;
        tick(10);
        chk("hold_value", {4'd0, bus.value}, 8'h05);
        chk("hold_pressed", {4'd0, bus.pressed}, 8'h01);
        #2 rst = 1'b1;
        #1;
        chk("midreset_value",   {4'd0, bus.value},   8'h00);
        chk("midreset_pressed", {4'd0, bus.pressed}, 8'h00);
        chk("midreset_locked",  {7'd0, bus.locked},  8'h00);
        tick(1);
        rst = 1'b0;
        tick(6);
        chk("rehold_value_before", {4'd0, bus.value}, 8'h00);
        chk("rehold_pressed", {4'd0, bus.pressed}, 8'h01);
        tick(1);
        chk("rehold_value", {4'd0, bus.value}, 8'h01);
        chk("rehold_update", {7'd0, bus.update}, 8'h01);
        bus.KEY = 4'hF;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
